// File: rtl/highscore_table.sv
// Sorted leaderboard of the DEPTH lowest non-zero reaction times.
// New entries are placed by an insertion FSM that shifts one slot per cycle.
module highscore_table #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             submit_valid,
  output logic             submit_ready,
  input  logic [WIDTH-1:0] submit_time,
  output logic             result_valid,
  output logic             result_accepted,
  output logic [AW:0]      result_rank,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] best_time,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_time,
  output logic             rd_valid
);

  typedef enum logic {IDLE, PLACE} state_t;

  state_t                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   entry_q, entry_d;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [AW-1:0]                 ptr_q, ptr_d;
  logic [WIDTH-1:0]              v_q, v_d;
  logic                          res_valid_q, res_valid_d;
  logic                          res_acc_q, res_acc_d;
  logic [AW:0]                   res_rank_q, res_rank_d;

  logic             full, reject, do_shift;
  logic [WIDTH-1:0] prev;

  assign full   = (count_q == CW'(DEPTH));
  assign reject = (submit_time == '0) || (full && submit_time >= entry_q[DEPTH-1]);
  // prev wraps to the tail when ptr is 0; do_shift masks that case out
  assign prev     = entry_q[ptr_q - AW'(1)];
  assign do_shift = (ptr_q != '0) && (v_q < prev);

  always_ff @(posedge clk) begin
    if (rst || clear) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (submit_valid && !reject) state_d = PLACE;
      PLACE:   if (!do_shift)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    submit_ready = (state_q == IDLE);
  end

  always_comb begin
    entry_d     = entry_q;
    valid_d     = valid_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    v_d         = v_q;
    res_valid_d = 1'b0;
    res_acc_d   = res_acc_q;
    res_rank_d  = res_rank_q;
    case (state_q)
      IDLE: begin
        if (submit_valid) begin
          v_d = submit_time;
          if (reject) begin
            res_valid_d = 1'b1;
            res_acc_d   = 1'b0;
            res_rank_d  = (AW+1)'(DEPTH);
          end else begin
            // a full table sacrifices its tail slot
            ptr_d = full ? AW'(DEPTH - 1) : count_q[AW-1:0];
          end
        end
      end
      PLACE: begin
        valid_d[ptr_q] = 1'b1;
        if (do_shift) begin
          entry_d[ptr_q] = prev;
          ptr_d          = ptr_q - AW'(1);
        end else begin
          entry_d[ptr_q] = v_q;
          if (!full) count_d = count_q + CW'(1);
          res_valid_d = 1'b1;
          res_acc_d   = 1'b1;
          res_rank_d  = {1'b0, ptr_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      entry_q     <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      v_q         <= '0;
      res_valid_q <= 1'b0;
      res_acc_q   <= 1'b0;
      res_rank_q  <= '0;
    end else begin
      entry_q     <= entry_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      v_q         <= v_d;
      res_valid_q <= res_valid_d;
      res_acc_q   <= res_acc_d;
      res_rank_q  <= res_rank_d;
    end
  end

  always_comb begin
    rd_time  = '0;
    rd_valid = 1'b0;
    if (int'(rd_idx) < DEPTH) begin
      rd_time  = entry_q[rd_idx];
      rd_valid = valid_q[rd_idx];
    end
  end

  assign result_valid    = res_valid_q;
  assign result_accepted = res_acc_q;
  assign result_rank     = res_rank_q;
  assign count           = count_q;
  assign best_time       = valid_q[0] ? entry_q[0] : '0;

endmodule

// File: tb/tb_highscore_table.sv
// Directed vector bench for highscore_table (WIDTH=24, DEPTH=4).
module tb_highscore_table;
  logic        clk = 1'b0;
  logic        rst, clear, submit_valid, submit_ready;
  logic [23:0] submit_time, best_time, rd_time;
  logic        result_valid, result_accepted, rd_valid;
  logic [2:0]  result_rank, count;
  logic [1:0]  rd_idx;

  int n_chk = 0;
  int n_fail = 0;

  highscore_table #(.WIDTH(24), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .submit_valid(submit_valid), .submit_ready(submit_ready), .submit_time(submit_time),
    .result_valid(result_valid), .result_accepted(result_accepted), .result_rank(result_rank),
    .count(count), .best_time(best_time),
    .rd_idx(rd_idx), .rd_time(rd_time), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [23:0] t;
    logic        acc;
    logic [2:0]  rank;
    int          lat;
    logic [2:0]  cnt;
    logic [23:0] best;
    int          tab[4];
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic clr, int t, logic acc, int rank, int lat, int cnt,
                              int best, int e0, int e1, int e2, int e3);
    vec_t v;
    v.clr = clr; v.t = 24'(t); v.acc = acc; v.rank = 3'(rank); v.lat = lat;
    v.cnt = 3'(cnt); v.best = 24'(best);
    v.tab[0] = e0; v.tab[1] = e1; v.tab[2] = e2; v.tab[3] = e3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  // Offers t, returns cycles from the accept edge to the result pulse.
  task automatic submit(input logic [23:0] t, output int lat, output logic acc,
                        output logic [2:0] rank);
    int w;
    w = 0;
    @(negedge clk);
    while (!submit_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_submit", {31'd0, submit_ready}, 32'd1);
    submit_valid = 1'b1;
    submit_time  = t;
    @(posedge clk);
    #1 submit_valid = 1'b0;
    lat = 0;
    acc = 1'b0;
    rank = 3'd7;
    do begin
      @(negedge clk);
      lat++;
    end while (!result_valid && lat < 20);
    if (result_valid) begin
      acc = result_accepted;
      rank = result_rank;
    end else begin
      chk("result_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic check_table(input string tag, input int tab[4]);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      chk($sformatf("%s_rd_time[%0d]", tag, i), {8'd0, rd_time}, 32'(tab[i]));
      chk($sformatf("%s_rd_valid[%0d]", tag, i), {31'd0, rd_valid}, {31'd0, tab[i] != 0});
    end
  endtask

  initial begin
    int lat;
    logic acc;
    logic [2:0] rank;
    int tb4[4];
    bit seen;

    vecs[0]  = mk(0, 500, 1, 0, 2, 1, 500, 500, 0, 0, 0);
    vecs[1]  = mk(1, 300, 1, 0, 2, 1, 300, 300, 0, 0, 0);
    vecs[2]  = mk(0, 700, 1, 1, 2, 2, 300, 300, 700, 0, 0);
    vecs[3]  = mk(0, 100, 1, 0, 4, 3, 100, 100, 300, 700, 0);
    vecs[4]  = mk(0, 400, 1, 2, 3, 4, 100, 100, 300, 400, 700);
    vecs[5]  = mk(0, 800, 0, 4, 1, 4, 100, 100, 300, 400, 700);
    vecs[6]  = mk(0, 700, 0, 4, 1, 4, 100, 100, 300, 400, 700);
    vecs[7]  = mk(0, 0,   0, 4, 1, 4, 100, 100, 300, 400, 700);
    vecs[8]  = mk(0, 50,  1, 0, 5, 4, 50,  50, 100, 300, 400);
    vecs[9]  = mk(1, 100, 1, 0, 2, 1, 100, 100, 0, 0, 0);
    vecs[10] = mk(0, 300, 1, 1, 2, 2, 100, 100, 300, 0, 0);
    vecs[11] = mk(0, 300, 1, 2, 2, 3, 100, 100, 300, 300, 0);

    rst = 1'b1; clear = 1'b0; submit_valid = 1'b0; submit_time = '0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, submit_ready}, 32'd1);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_result_accepted", {31'd0, result_accepted}, 32'd0);
    chk("rst_result_rank", {29'd0, result_rank}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_best", {8'd0, best_time}, 32'd0);
    chk("rst_rd_time", {8'd0, rd_time}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].clr) do_clear();
      submit(vecs[i].t, lat, acc, rank);
      chk($sformatf("v%0d_accepted", i), {31'd0, acc}, {31'd0, vecs[i].acc});
      chk($sformatf("v%0d_rank", i), {29'd0, rank}, {29'd0, vecs[i].rank});
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].cnt});
      chk($sformatf("v%0d_best", i), {8'd0, best_time}, {8'd0, vecs[i].best});
      check_table($sformatf("v%0d", i), vecs[i].tab);
    end

    // Fill to {100,300,300,900}, then clear partway through inserting 50.
    submit(24'd900, lat, acc, rank);
    chk("fill_rank", {29'd0, rank}, 32'd3);
    chk("fill_count", {29'd0, count}, 32'd4);
    @(negedge clk);
    submit_valid = 1'b1;
    submit_time  = 24'd50;
    @(posedge clk);
    #1 submit_valid = 1'b0;
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("midclr_ready", {31'd0, submit_ready}, 32'd1);
    chk("midclr_count", {29'd0, count}, 32'd0);
    chk("midclr_best", {8'd0, best_time}, 32'd0);
    seen = result_valid;
    repeat (8) begin
      @(negedge clk);
      seen |= result_valid;
    end
    chk("midclr_no_pulse", {31'd0, seen}, 32'd0);
    tb4 = '{0, 0, 0, 0};
    check_table("midclr", tb4);

    // Submit coincident with clear is dropped.
    @(negedge clk);
    clear = 1'b1; submit_valid = 1'b1; submit_time = 24'd200;
    @(posedge clk);
    #1 begin clear = 1'b0; submit_valid = 1'b0; end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= result_valid;
    end
    chk("clrsub_no_pulse", {31'd0, seen}, 32'd0);
    chk("clrsub_count", {29'd0, count}, 32'd0);

    // Three back-to-back zero submissions: three consecutive reject pulses.
    @(negedge clk);
    submit_valid = 1'b1;
    submit_time  = 24'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      if (i == 2) #1 submit_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b%0d_valid", i), {31'd0, result_valid}, 32'd1);
      chk($sformatf("b2b%0d_accepted", i), {31'd0, result_accepted}, 32'd0);
      chk($sformatf("b2b%0d_rank", i), {29'd0, result_rank}, 32'd4);
      chk($sformatf("b2b%0d_ready", i), {31'd0, submit_ready}, 32'd1);
    end
    @(negedge clk);
    chk("b2b_pulse_end", {31'd0, result_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
